// File: rtl/dac_wb_wrapper_if.sv
// dac_wb_wrapper_if: Wishbone classic slave bundle for the DAC wrapper.
// The master drives cycle/strobe/address/data; the slave returns ack and read data.
interface dac_wb_wrapper_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/dac_wb_wrapper.sv
// dac_wb_wrapper: Wishbone-mapped DAC sample player draining a FIFO every PERIOD+1 clocks.
// Define DAC_FIFO_EN for an 8-entry sample FIFO; otherwise a one-entry holding register.
module dac_wb_wrapper #(
  parameter int PRESCALE_W = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  dac_wb_wrapper_if.slave wb,
  output logic [11:0]     dac_val,
  output logic            dac_en,
  output logic            dac_load,
  output logic            irq
);
`ifdef DAC_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]    DEPTH_L = 4'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  localparam logic [6:0] A_DATA = 7'h00;
  localparam logic [6:0] A_CTRL = 7'h01;
  localparam logic [6:0] A_STAT = 7'h02;
  localparam logic [6:0] A_PER  = 7'h03;
  localparam logic [6:0] A_IM   = 7'h3F;
  localparam logic [6:0] A_RIS  = 7'h40;
  localparam logic [6:0] A_MIS  = 7'h41;
  localparam logic [6:0] A_IC   = 7'h42;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic [31:0]           rdat_q, rdat_d;
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] per_q, per_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [2:0]            im_q, im_d;
  logic [2:0]            ris_q, ris_d;
  logic [11:0]           val_q, val_d;
  logic                  load_q, load_d;
  logic [AW-1:0]         rp_q, rp_d;
  logic [AW-1:0]         wp_q, wp_d;
  logic [3:0]            lvl_q, lvl_d;
  logic [11:0]           mem_q [DEPTH];

  logic       commit, wr, rd, flush, tick;
  logic       empty, full, pop, push, push_ok;
  logic [6:0] idx;
  logic [2:0] ris_set, ris_clr;
  logic       unused_ok;

  assign unused_ok = ^{wb.wbs_sel_i, wb.wbs_adr_i[31:9],
                       wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:12]};

  always_comb begin
    idx    = wb.wbs_adr_i[8:2];
    commit = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
    wr     = commit & wb.wbs_we_i;
    rd     = commit & ~wb.wbs_we_i;
    ack_d  = commit;
    empty  = lvl_q == 4'd0;
    full   = lvl_q == DEPTH_L;
    en_d   = en_q;
    per_d  = per_q;
    im_d   = im_q;
    flush  = 1'b0;
    unique case (1'b1)
      wr && idx == A_CTRL: begin
        en_d  = wb.wbs_dat_i[0];
        flush = wb.wbs_dat_i[1];
      end
      wr && idx == A_PER: per_d = wb.wbs_dat_i[PRESCALE_W-1:0];
      wr && idx == A_IM:  im_d = wb.wbs_dat_i[2:0];
      default: ;
    endcase
    push    = wr && idx == A_DATA;
    ris_clr = (wr && idx == A_IC) ? wb.wbs_dat_i[2:0] : 3'b000;

    state_d = state_q;
    cnt_d   = cnt_q;
    tick    = 1'b0;
    unique case (state_q)
      IDLE: if (en_d) begin
        state_d = RUN;
        cnt_d   = per_q;
      end
      RUN: if (!en_d) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt_q == '0) begin
        tick  = 1'b1;
        cnt_d = per_q;
      end else begin
        cnt_d = cnt_q - PRESCALE_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over a coinciding tick; a full FIFO still accepts when popping.
    pop     = tick & ~empty & ~flush;
    push_ok = push & (~full | pop);
    ris_set = {push & ~push_ok,
               pop & (lvl_q == 4'd1) & ~push_ok,
               tick & empty};
    ris_d   = (ris_q & ~ris_clr) | ris_set;

    rp_d   = rp_q;
    wp_d   = wp_q;
    lvl_d  = lvl_q;
    val_d  = val_q;
    load_d = pop;
    if (flush) begin
      rp_d  = '0;
      wp_d  = '0;
      lvl_d = '0;
    end else begin
      if (pop) begin
        rp_d  = (rp_q == LAST) ? '0 : rp_q + AW'(1);
        val_d = mem_q[rp_q];
      end
      if (push_ok)
        wp_d = (wp_q == LAST) ? '0 : wp_q + AW'(1);
      lvl_d = lvl_q + 4'(push_ok) - 4'(pop);
    end

    rdat_d = rdat_q;
    if (rd) begin
      unique case (1'b1)
        idx == A_DATA: rdat_d = {20'b0, val_q};
        idx == A_CTRL: rdat_d = {31'b0, en_q};
        idx == A_STAT: rdat_d = {25'b0, state_q == RUN,
                                 full, empty, lvl_q};
        idx == A_PER:  rdat_d = 32'(per_q);
        idx == A_IM:   rdat_d = {29'b0, im_q};
        idx == A_RIS:  rdat_d = {29'b0, ris_q};
        idx == A_MIS:  rdat_d = {29'b0, ris_q & im_q};
        idx == A_IC:   rdat_d = 32'h0;
        default:       rdat_d = 32'hDEADBEEF;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      en_q    <= 1'b0;
      per_q   <= '0;
      cnt_q   <= '0;
      im_q    <= '0;
      ris_q   <= '0;
      val_q   <= '0;
      load_q  <= 1'b0;
      rp_q    <= '0;
      wp_q    <= '0;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      en_q    <= en_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
      im_q    <= im_d;
      ris_q   <= ris_d;
      val_q   <= val_d;
      load_q  <= load_d;
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      lvl_q   <= lvl_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok && !flush)
      mem_q[wp_q] <= wb.wbs_dat_i[11:0];
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = rdat_q;
  assign dac_val      = val_q;
  assign dac_en       = en_q;
  assign dac_load     = load_q;
  assign irq          = |(ris_q & im_q);
endmodule

// File: tb/tb_dac_wb_wrapper.sv
// tb_dac_wb_wrapper: directed scenarios plus randomized bus traffic,
// checked against a queue-based reference model of the DAC player.
module tb_dac_wb_wrapper;
`ifdef DAC_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [6:0] I_DATA = 7'h00;
  localparam logic [6:0] I_CTRL = 7'h01;
  localparam logic [6:0] I_STAT = 7'h02;
  localparam logic [6:0] I_PER  = 7'h03;
  localparam logic [6:0] I_IM   = 7'h3F;
  localparam logic [6:0] I_RIS  = 7'h40;
  localparam logic [6:0] I_MIS  = 7'h41;
  localparam logic [6:0] I_IC   = 7'h42;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] dac_val;
  logic        dac_en, dac_load, irq;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc_n = 0;

  dac_wb_wrapper_if bus();

  dac_wb_wrapper #(.PRESCALE_W(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus),
    .dac_val  (dac_val),
    .dac_en   (dac_en),
    .dac_load (dac_load),
    .irq      (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic        m_ack, m_en, m_run, m_load;
  logic [2:0]  m_im, m_ris;
  logic [11:0] m_val;
  logic [31:0] m_rdata;
  int          m_period, m_elapsed;
  logic [11:0] m_q[$];

  function automatic logic [31:0] rd_value(input logic [6:0] idx);
    int lv = m_q.size();
    case (idx)
      I_DATA: return {20'b0, m_val};
      I_CTRL: return {31'b0, m_en};
      I_STAT: return 32'(lv) | (lv == 0 ? 32'h10 : 32'h0)
                   | (lv == DEPTH ? 32'h20 : 32'h0)
                   | (m_run ? 32'h40 : 32'h0);
      I_PER:  return 32'(m_period);
      I_IM:   return {29'b0, m_im};
      I_RIS:  return {29'b0, m_ris};
      I_MIS:  return {29'b0, m_ris & m_im};
      I_IC:   return 32'h0;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic model_reset();
    m_ack = 0; m_en = 0; m_run = 0; m_load = 0;
    m_im = 0; m_ris = 0; m_val = 0; m_rdata = 0;
    m_period = 0; m_elapsed = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic commit, wr, flush, en_nx, tick, pop, push;
    logic [6:0] idx;
    logic [31:0] d;
    logic [2:0] set, clr;
    int pre;
    commit = bus.wbs_cyc_i && bus.wbs_stb_i && !m_ack;
    wr     = commit && bus.wbs_we_i;
    idx    = bus.wbs_adr_i[8:2];
    d      = bus.wbs_dat_i;
    pre    = m_q.size();
    if (commit && !bus.wbs_we_i) m_rdata = rd_value(idx);
    en_nx = (wr && idx == I_CTRL) ? d[0] : m_en;
    flush = wr && idx == I_CTRL && d[1];
    push  = wr && idx == I_DATA;
    tick  = 0;
    if (m_run && en_nx) begin
      m_elapsed++;
      tick = (m_elapsed % (m_period + 1)) == 0;
    end else begin
      m_elapsed = 0;
    end
    set = 0;
    pop = 0;
    if (tick && pre == 0) set[0] = 1;
    else if (tick && !flush) pop = 1;
    if (flush) begin
      m_q.delete();
    end else begin
      if (pop) m_val = m_q.pop_front();
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(d[11:0]);
        else set[2] = 1;
      end
      if (pop && pre == 1 && m_q.size() == 0) set[1] = 1;
    end
    clr = (wr && idx == I_IC) ? d[2:0] : 3'b000;
    m_ris = (m_ris & ~clr) | set;
    if (wr && idx == I_PER) m_period = int'(d[15:0]);
    if (wr && idx == I_IM) m_im = d[2:0];
    m_load = pop;
    m_en   = en_nx;
    m_run  = en_nx;
    m_ack  = commit;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("dac_val", 32'(dac_val), 32'(m_val));
    chk("dac_load", 32'(dac_load), 32'(m_load));
    chk("dac_en", 32'(dac_en), 32'(m_en));
    chk("irq", 32'(irq), 32'(|(m_ris & m_im)));
    chk("ack", 32'(bus.wbs_ack_o), 32'(m_ack));
  end

  task automatic wb_xfer(input logic we, input logic [6:0] idx,
                         input logic [31:0] dat, output logic [31:0] rd);
    logic [31:0] r = $urandom;
    int n = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = {r[31:9], idx, r[1:0]};
    bus.wbs_sel_i = r[7:4];
    bus.wbs_dat_i = dat;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.wbs_ack_o && n < 8);
    chk("ack_seen", 32'(bus.wbs_ack_o), 32'd1);
    rd = bus.wbs_dat_o;
    if (!we) chk("rdata", rd, m_rdata);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [6:0] idx, input logic [31:0] dat);
    logic [31:0] x;
    wb_xfer(1'b1, idx, dat, x);
  endtask

  task automatic rdc(input logic [6:0] idx, input logic [31:0] exp,
                     input string tag);
    logic [31:0] v;
    wb_xfer(1'b0, idx, 32'h0, v);
    chk(tag, v, exp);
  endtask

  task automatic rdm(input logic [6:0] idx);
    logic [31:0] v;
    wb_xfer(1'b0, idx, 32'h0, v);
  endtask

  task automatic wait_load(output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dac_load && n < 64);
    chk("load_seen", 32'(dac_load), 32'd1);
    at = cyc_n;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [6:0] pick_idx(input int n);
    case (n)
      0: return I_DATA;
      1: return I_CTRL;
      2: return I_STAT;
      3: return I_PER;
      4: return I_IM;
      5: return I_RIS;
      6: return I_MIS;
      7: return I_IC;
      default: return 7'($urandom_range(4, 62));
    endcase
  endfunction

  initial begin
    int t0, t1, t2;
    logic [31:0] r;
    bus.wbs_cyc_i = 0;
    bus.wbs_stb_i = 0;
    bus.wbs_we_i  = 0;
    bus.wbs_sel_i = 0;
    bus.wbs_dat_i = 0;
    bus.wbs_adr_i = 0;
    do_reset();

    rdc(I_STAT, 32'h10, "rst_status");
    rdc(I_CTRL, 32'h0, "rst_ctrl");
    rdc(7'h10, 32'hDEADBEEF, "unmapped");

    // two samples at PERIOD=3
    wr(I_PER, 32'd3);
    wr(I_DATA, 32'h123);
    wr(I_CTRL, 32'h1);
    t0 = cyc_n;
    wait_load(t1);
    chk("lat_first", 32'(t1 - t0), 32'd4);
    chk("val_first", 32'(dac_val), 32'h123);
    @(posedge clk);
    #1;
    wr(I_DATA, 32'h456);
    wait_load(t2);
    chk("lat_second", 32'(t2 - t1), 32'd4);
    chk("val_second", 32'(dac_val), 32'h456);
    @(posedge clk);
    #1;
    wr(I_CTRL, 32'h0);
    rdc(I_RIS, 32'h2, "ris_empty");

    // underrun with empty FIFO
    do_reset();
    wr(I_IM, 32'h1);
    wr(I_PER, 32'd1);
    wr(I_CTRL, 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk("irq_early", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_underrun", 32'(irq), 32'd1);
    chk("val_held", 32'(dac_val), 32'd0);
    @(posedge clk);
    #1;
    wr(I_IM, 32'h0);
    @(negedge clk);
    chk("irq_masked", 32'(irq), 32'd0);
    rdc(I_RIS, 32'h1, "ris_underrun");
    wr(I_CTRL, 32'h0);

    // overflow
    do_reset();
    for (int i = 1; i <= 9; i++) wr(I_DATA, 32'(i));
    rdc(I_STAT, 32'h20 | 32'(DEPTH), "status_full");
    rdc(I_RIS, 32'h4, "ris_overflow");
    wr(I_PER, 32'd0);
    wr(I_CTRL, 32'h1);
    repeat (20) @(posedge clk);
    #1;
    chk("last_sample", 32'(dac_val), 32'(DEPTH));
    wr(I_CTRL, 32'h0);

    // flush
    do_reset();
    for (int i = 0; i < 5; i++) wr(I_DATA, 32'(i + 16));
    wr(I_CTRL, 32'h2);
    rdc(I_STAT, 32'h10, "status_flush");
    rdc(I_CTRL, 32'h0, "ctrl_flush");

    // clear coincident with underrun
    do_reset();
    wr(I_PER, 32'd0);
    for (int i = 0; i <= DEPTH; i++) wr(I_DATA, 32'(i + 32));
    wr(I_CTRL, 32'h1);
    repeat (DEPTH + 4) @(posedge clk);
    #1;
    rdc(I_RIS, 32'h7, "ris_all");
    wr(I_IC, 32'h7);
    rdc(I_RIS, 32'h1, "ris_ic_race");
    wr(I_CTRL, 32'h0);

    // reset mid-run
    do_reset();
    wr(I_IM, 32'h7);
    wr(I_PER, 32'd20);
    wr(I_DATA, 32'hABC);
    wr(I_CTRL, 32'h1);
    wait_load(t1);
    for (int i = 0; i < 3; i++) wr(I_DATA, 32'(i + 48));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_val", 32'(dac_val), 32'd0);
    chk("arst_en", 32'(dac_en), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_ack", 32'(bus.wbs_ack_o), 32'd0);
    chk("arst_load", 32'(dac_load), 32'd0);
    do_reset();
    rdc(I_STAT, 32'h10, "status_after_rst");
    repeat (10) @(posedge clk);
    #1;

    // randomized traffic
    do_reset();
    for (int k = 0; k < 300; k++) begin
      r = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: wr(I_DATA, r);
        3: wr(I_CTRL, {r[31:2], ($urandom_range(0, 3) == 0), r[0]});
        4: if (!m_en) wr(I_PER, 32'($urandom_range(0, 4)));
        5: wr(I_IM, r);
        6: wr(I_IC, r);
        7, 8: rdm(pick_idx($urandom_range(0, 8)));
        default: begin
          repeat ($urandom_range(1, 6)) @(posedge clk);
          #1;
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dac_wb_wrapper.md
DAC_WB_WRAPPER -- requirements
Module: dac_wb_wrapper

Interface
REQ-001 SHALL have port wb_clk_i, in, 1: sole clock; all logic on its rising edge.
REQ-002 SHALL have port wb_rst_i, in, 1: reset, asynchronous, active-high.
REQ-003 SHALL have Wishbone slave ports wbs_cyc_i, wbs_stb_i, wbs_we_i (in, 1 each); wbs_sel_i (in, 4); wbs_dat_i (in, 32); wbs_adr_i (in, 32).
REQ-004 SHALL have wbs_ack_o (out, 1) and wbs_dat_o (out, 32): bus acknowledge and read data.
REQ-005 SHALL have dac_val (out, 12): code driven to the analog DAC.
REQ-006 SHALL have dac_en (out, 1): DAC enable, equal to CTRL.EN.
REQ-007 SHALL have dac_load (out, 1): one-cycle pulse when dac_val changes from the FIFO.
REQ-008 SHALL have irq (out, 1): OR of MIS bits.
REQ-009 SHALL have parameter PRESCALE_W, default 16: width of the sample-period register.

Function
REQ-010 SHALL decode wbs_adr_i[8:2]: DATA 0x00, CTRL 0x04, STATUS 0x08, PERIOD 0x0C, IM 0xFC, RIS 0x100, MIS 0x104, IC 0x108; other addresses read 0xDEADBEEF and ignore writes.
REQ-011 SHALL assert wbs_ack_o one cycle after cyc&stb with ack low, and hold it for one cycle only; a transfer commits its side effects only in the cycle ack rises (cyc&stb&!ack).
REQ-012 SHALL push wbs_dat_i[11:0] into an 8-entry sample FIFO on a committed DATA write; a DATA read returns {20'b0, dac_val}.
REQ-013 SHALL have CTRL: bit0 EN, bit1 FLUSH (self-clearing, empties FIFO, reads 0).
REQ-014 SHALL have STATUS: [3:0] FIFO level 0..8, bit4 empty, bit5 full, bit6 running (state RUN).
REQ-015 SHALL use PERIOD[PRESCALE_W-1:0] so that one sample is consumed every PERIOD+1 clocks; PERIOD=0 gives one sample per clock.
REQ-016 SHALL use an FSM with states IDLE and RUN: IDLE->RUN when EN=1 (counter loaded with PERIOD); RUN->IDLE when EN=0 (counter cleared, dac_val held).
REQ-017 SHALL, in RUN, when the counter reaches 0 with FIFO non-empty: pop, update dac_val, pulse dac_load, reload the counter; first update at PERIOD+1 clocks after entering RUN.
REQ-018 SHALL, on a tick with FIFO empty: hold dac_val, no dac_load, set RIS bit0 (UNDERRUN), reload the counter.
REQ-019 SHALL set RIS bit1 (EMPTY) on the cycle a pop makes the level go 1->0.
REQ-020 SHALL drop a push when full with no same-cycle pop and set RIS bit2 (OVERFLOW); a push and a pop in the same cycle when full SHALL both succeed, level unchanged.
REQ-021 SHALL give FLUSH priority over a same-cycle push or pop; the level becomes 0 and no pop or dac_load occurs.
REQ-022 SHALL clear each RIS bit written 1 to IC; a same-cycle set SHALL take priority over the clear.
REQ-023 SHALL compute MIS = RIS & IM[2:0]; irq = |MIS, combinational from registers.
REQ-024 SHALL ignore wbs_sel_i; all writes are full-word.

Reset
REQ-025 SHALL, on wb_rst_i, immediately set: wbs_ack_o=0, dac_val=0, dac_load=0, dac_en=0, irq=0, CTRL=0, PERIOD=0, IM=0, RIS=0, FIFO empty, state IDLE.
REQ-026 SHALL, on reset mid-transfer or mid-RUN, discard queued samples and produce no dac_load until after re-enable.

Configuration
REQ-027 SHALL, with DAC_FIFO_EN defined, build the 8-entry FIFO as specified.
REQ-028 SHALL, without DAC_FIFO_EN, replace the FIFO with a one-entry holding register: level 0..1; full when level=1; all other rules unchanged.

Verification
REQ-029 SHALL show: PERIOD=3, push 0x123, 0x456, EN=1 -> dac_val=0x123 with dac_load 4 clocks after EN, 0x456 4 clocks later, then RIS=0b010.
REQ-030 SHALL show: EN=1 with FIFO empty and PERIOD=1 -> RIS bit0 set after 2 clocks; dac_val stays 0; irq=1 only if IM bit0=1.
REQ-031 SHALL show: push 9 samples with EN=0 -> level 8, full=1, RIS bit2=1; 9th sample is never output.
REQ-032 SHALL show: write FLUSH with level 5 -> STATUS level 0, empty=1, CTRL reads 0.
REQ-033 SHALL show: write IC=0x7 on a cycle coincident with an underrun -> RIS bit0 stays 1, bits 1-2 clear.
REQ-034 SHALL show: assert wb_rst_i mid-RUN with level 3 -> all outputs 0 asynchronously; after release STATUS=0x10.
